// File: rtl/mbc2_cram_xfer.sv
// mbc2_cram_xfer: cart-bus initiator that dumps/restores the MBC2 512x4 RAM as a byte stream
module mbc2_cram_xfer #(
  parameter int          NIBBLES   = 512,
  parameter logic [7:0]  EN_VALUE  = 8'h0A,
  parameter logic [7:0]  DIS_VALUE = 8'h00
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_cpu,
  input  logic        start,
  input  logic        dir,
  output logic        busy,
  output logic        done,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [14:0] cart_addr,
  output logic        cart_a15,
  output logic        cart_rd,
  output logic        cart_wr,
  output logic [7:0]  cart_do,
  input  logic [7:0]  cart_ram_di,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready
);
  typedef enum logic [3:0] {IDLE, REQ, EN, RD, PUSH, FETCH, WR, DIS, FIN} state_t;
  localparam logic [9:0] LAST = 10'(NIBBLES);
  state_t state, state_n;
  logic dir_r;
  logic [9:0] idx, idx_inc;
  logic [7:0] hold;
  logic acc_st, ram_st, g, acc, unused_hi;
  assign unused_hi = ^cart_ram_di[7:4];
  assign idx_inc = idx + 10'd1;
  assign acc_st = state inside {EN, RD, WR, DIS};
  assign ram_st = state inside {RD, WR};
  assign g = acc_st & bus_gnt;
  assign acc = g & ce_cpu;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? REQ : IDLE;
      REQ:     state_n = bus_gnt ? EN : REQ;
      EN:      state_n = !acc ? EN : dir_r ? FETCH : RD;
      RD:      state_n = (acc && idx[0]) ? PUSH : RD;
      PUSH:    state_n = !out_ready ? PUSH : (idx == LAST) ? DIS : RD;
      FETCH:   state_n = in_valid ? WR : FETCH;
      WR:      state_n = !(acc && idx[0]) ? WR : (idx_inc == LAST) ? DIS : FETCH;
      DIS:     state_n = acc ? FIN : DIS;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    busy      = state != IDLE;
    done      = state == FIN;
    bus_req   = busy & ~done;
    cart_addr = (g & ram_st) ? {6'b010000, idx[8:0]} : 15'h0000;
    cart_a15  = g & ram_st;
    cart_rd   = g & (state == RD);
    cart_wr   = g & (state inside {EN, WR, DIS});
    cart_do   = !g             ? 8'h00 :
                state == EN    ? EN_VALUE :
                state == DIS   ? DIS_VALUE :
                state == WR    ? {4'h0, idx[0] ? hold[7:4] : hold[3:0]} : 8'h00;
    out_valid = state == PUSH;
    out_data  = out_valid ? hold : 8'h00;
    in_ready  = state == FETCH;
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dir_r <= 1'b0;
      idx   <= '0;
      hold  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        dir_r <= dir;
        idx   <= '0;
      end
      if (acc && ram_st) idx <= idx_inc;
      // even nibble lands in the low half of the byte, odd in the high half
      if (acc && state == RD)
        hold <= idx[0] ? {cart_ram_di[3:0], hold[3:0]} : {hold[7:4], cart_ram_di[3:0]};
      if (state == FETCH && in_valid) hold <= in_data;
    end
  end
endmodule
